ps2_host_tx: RTL

PS/2 host-to-device transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset, 8'hF4 enable) from the FPGA to the keyboard over the same open-drain `ps2_clk`/`ps2_data` pair the keyboard receiver listens on. It implements the full host request-to-send sequence: inhibit, start bit, device-clocked shift-out, ack check, bus idle. It sits beside `keyboard`, under the top-level `main`, and owns the line drivers whenever `busy` is high.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_line_sync.sv | 46 ++++
 rtl/ps2_host_tx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 host-side blocks:
//               transmitter state encoding, frame geometry, command bytes
//               and the frame builder.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_ACK       = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } ps2_state_e;

  localparam int PS2_FRAME_BITS  = 10;
  localparam int PS2_SYNC_STAGES = 2;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // Host frame, LSB shifted first: data[7:0], odd parity, stop (1).
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_sync
// Description : Multi-flop synchronizers for the raw PS/2 clock and data
//               pins plus a falling-edge detector on the synchronized clock.
//               Shared by the host transmitter and the keyboard receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int STAGES = PS2_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [STAGES-1:0] clk_pipe;
  logic [STAGES-1:0] data_pipe;
  logic              clk_prev;

  // Shift the pins through the synchronizer chains; an idle bus is high, so
  // the chains reset to 1 to avoid a spurious edge when reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_pipe  <= '1;
      data_pipe <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_pipe  <= {clk_pipe[STAGES-2:0], ps2_clk_i};
      data_pipe <= {data_pipe[STAGES-2:0], ps2_data_i};
      clk_prev  <= clk_pipe[STAGES-1];
    end
  end

  assign clk_s  = clk_pipe[STAGES-1];
  assign data_s = data_pipe[STAGES-1];
  assign fall   = clk_prev & ~clk_pipe[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter. Performs the host
//               request-to-send sequence (clock inhibit, start bit, shift-out
//               on device clock, ack check, bus idle) over open-drain lines.
//               Optional build macro PS2_TX_RETRY_EN: a failed transfer
//               (NACK or timeout) is retried once with the same frame before
//               err is reported.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BIT_W = $clog2(PS2_FRAME_BITS);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PS2_FRAME_BITS - 1);

  ps2_state_e                state_q, state_d;
  logic [INH_W-1:0]          inh_q, inh_d;
  logic [TO_W-1:0]           to_q, to_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic                      clk_oe_q, clk_oe_d;
  logic                      data_oe_q, data_oe_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
`ifdef PS2_TX_RETRY_EN
  logic                      retry_q, retry_d;
`endif

  logic clk_s;
  logic data_s;
  logic fall;
  logic timed;
  logic fail;

  ps2_line_sync #(
    .STAGES(PS2_SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .clk_s     (clk_s),
    .data_s    (data_s),
    .fall      (fall)
  );

  assign timed = (state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);

  // Next-state, counters, frame shift and registered line/pulse outputs.
  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    to_d      = to_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    // The timeout window spans SHIFT, ACK and WAIT_IDLE; saturate, never wrap.
    if (timed && (to_q != TO_LAST)) begin
      to_d = to_q + TO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d  = ps2_build_frame(tx_data);
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d  = 1'b0;
`endif
        end
      end
      ST_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          // Clock release and start bit take effect on the same edge.
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          bit_d     = '0;
          state_d   = ST_SHIFT;
        end else if (inh_q != INH_LAST) begin
          inh_d = inh_q + INH_W'(1);
        end
      end
      ST_SHIFT: begin
        if (fall) begin
          data_oe_d = ~frame_q[bit_q];
          if (bit_q == BIT_LAST) begin
            state_d = ST_ACK;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_ACK: begin
        if (fall) begin
          if (!data_s) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // Timeout overrides whatever the state decided this cycle.
    if (timed && (to_q == TO_LAST)) begin
      fail = 1'b1;
    end

    if (fail) begin
      done_d    = 1'b0;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d  = 1'b1;
        clk_oe_d = 1'b1;
        state_d  = ST_INHIBIT;
      end else begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
`else
      err_d   = 1'b1;
      state_d = ST_IDLE;
`endif
    end

    // Every state entry restarts the inhibit counter; the timeout window
    // restarts only when the clock is released into SHIFT.
    if (state_d != state_q) begin
      inh_d = '0;
      if (state_d == ST_SHIFT) begin
        to_d = '0;
      end
    end
  end

  // State and datapath registers; reset releases both lines immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      inh_q     <= '0;
      to_q      <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      inh_q     <= inh_d;
      to_q      <= to_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign tx_ready    = ~busy;
  assign done        = done_q;
  assign err         = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
`default_nettype wire
